inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch front end driving the combinational instruction ROM.
//  Generates pc/ce for the ROM, captures each returned word with its PC into a
//  small prefetch FIFO, and presents entries to the IF/ID stage over valid/ready.
//  Handles branch redirect and exception flush by discarding queued fetches.
// PARAMETERS
//  DEPTH     4          prefetch FIFO entries; power of 2, >=2
//  RESET_PC  32'h0      fetch address after reset; word aligned
// PORTS
//  clk              in   1   clock; all state updates on rising edge
//  rst              in   1   reset; asynchronous, active-high
//  flush_i          in   1   exception/ERET redirect
//  new_pc_i         in   32  flush target
//  branch_flag_i    in   1   taken branch/jump redirect
//  branch_target_i  in   32  branch target
//  rom_inst_i       in   32  instruction word from ROM; valid in the same cycle as pc_o
//  pc_o             out  32  ROM fetch address
//  ce_o             out  1   ROM chip enable (1=ChipEnable)
//  id_valid_o       out  1   head entry valid
//  id_ready_i       in   1   IF/ID accepts head this cycle
//  id_pc_o          out  32  head entry PC
//  id_inst_o        out  32  head entry instruction
//  count_o          out  log2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset (async, immediate): ce_o=0, pc_o=RESET_PC, FIFO empty, count_o=0,
//   id_valid_o=0, id_pc_o=0, id_inst_o=0; storage contents don't-care.
//  Startup: ce_o goes 1 on the first rising edge after rst deasserts, then stays 1
//   until the next reset. pc_o is held at RESET_PC on that edge; no push occurs.
//  pop = id_valid_o & id_ready_i.
//  push = ce_o & ~flush_i & ~branch_flag_i & (count_o<DEPTH | pop).
//   On push: write {pc_o, rom_inst_i} to the tail; pc_o <= pc_o+4 (32-bit wrap,
//   32'hFFFF_FFFC -> 0). Full with no pop: no push; pc_o holds (refetched later).
//  Simultaneous push+pop: permitted at any count, including full; count unchanged.
//  Redirect priority: flush_i > branch_flag_i. When either is high at an edge:
//   pc_o <= target with bits[1:0] forced to 0; FIFO cleared (count 0);
//   no push; any pop that cycle is still counted by the consumer but the entry is
//   discarded with the rest. Redirect while ce_o=0 sets pc_o; ce_o still rises.
//  Outputs: id_valid_o = (count_o!=0); id_pc_o/id_inst_o = head entry, driven
//   combinationally from storage; forced to 0 when empty.
//  Latency: a word fetched in cycle N is visible at id_* in cycle N+1 if the FIFO
//   was empty.
//  Throughput: one fetch and one issue per cycle sustained.
//  Pointers: read/write indices wrap modulo DEPTH; count_o distinguishes full
//   from empty.
//  Reset mid-operation: all state returns to the reset values immediately,
//   regardless of in-flight push, pop, or redirect.
// TESTING
//  1. Reset, then release with ROM[i]=i, id_ready_i=1 -> ce_o rises at edge 1;
//     id stream (0,0),(4,1),(8,2)... one entry per cycle.
//  2. id_ready_i=0 for 10 cycles -> count_o saturates at DEPTH=4, pc_o holds at
//     16, entries 0..12 retained; release ready -> in-order drain, no loss or duplicate.
//  3. Full FIFO with id_ready_i=1 -> push+pop each cycle, count_o stays 4.
//  4. branch_flag_i=1, target 32'h100, with 3 queued -> next cycle count_o=0,
//     pc_o=0x100; first id entry is PC 0x100.
//  5. flush_i=1 (new_pc 0x20) and branch_flag_i=1 (target 0x40) in the same cycle
//     -> pc_o=0x20; target 0x43 -> pc_o=0x40.
//  6. pc_o=32'hFFFF_FFFC push -> pc_o=0; assert rst mid-stream -> outputs zero
//     immediately; release -> fetch resumes from RESET_PC.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction-fetch bus bundle.
// Groups the ROM fetch port, the redirect inputs and the IF/ID valid/ready port of
// inst_fetch. Signal names keep their direction suffix as seen from the fetch unit.
//   master : the fetch unit (inst_fetch)
//   slave  : the environment (ROM, redirect sources, IF/ID consumer)
// Signals:
//   flush_i / new_pc_i                 exception/ERET redirect and its target
//   branch_flag_i / branch_target_i    taken branch/jump redirect and its target
//   rom_inst_i                         ROM word for pc_o, valid in the same cycle
//   pc_o / ce_o                        ROM fetch address and chip enable
//   id_valid_o / id_ready_i            IF/ID handshake for the FIFO head
//   id_pc_o / id_inst_o                head entry PC and instruction
//   count_o                            occupied prefetch entries
interface inst_fetch_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush_i;
  logic [31:0]   new_pc_i;
  logic          branch_flag_i;
  logic [31:0]   branch_target_i;
  logic [31:0]   rom_inst_i;
  logic [31:0]   pc_o;
  logic          ce_o;
  logic          id_valid_o;
  logic          id_ready_i;
  logic [31:0]   id_pc_o;
  logic [31:0]   id_inst_o;
  logic [CW-1:0] count_o;

  modport master (
    input  flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_inst_i, id_ready_i,
    output pc_o, ce_o, id_valid_o, id_pc_o, id_inst_o, count_o
  );

  modport slave (
    output flush_i, new_pc_i, branch_flag_i, branch_target_i, rom_inst_i, id_ready_i,
    input  pc_o, ce_o, id_valid_o, id_pc_o, id_inst_o, count_o
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch front end.
// Drives pc/ce to a combinational instruction ROM, captures each returned word with
// its PC into a DEPTH-entry prefetch FIFO and presents the head entry to IF/ID over
// valid/ready. A flush or taken branch redirects the PC and discards queued fetches.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  inst_fetch_if.master (ROM port, redirect inputs, IF/ID port, count)
// Parameters:
//   DEPTH     prefetch FIFO entries, power of 2, >= 2
//   RESET_PC  word-aligned fetch address after reset
module inst_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam int unsigned   AW         = $clog2(DEPTH);
  localparam int unsigned   CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // StIdle holds ce low for the first edge after reset, StRun fetches forever.
  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic          w_ce;

  logic [31:0]   r_pc;
  logic [31:0]   w_pc_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] w_rptr_next;
  logic [AW-1:0] w_wptr_next;

  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];

  logic          w_redirect;
  logic [31:0]   w_redirect_pc;
  logic          w_not_empty;
  logic          w_pop;
  logic          w_push;

  // ---------------------------------------------------------------------------
  // Startup FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ce         = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_state_next = StRun;
      end
      StRun: begin
        w_ce = 1'b1;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and redirect decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_redirect    = bus.flush_i | bus.branch_flag_i;
    // Flush outranks branch; targets are forced word aligned.
    w_redirect_pc = bus.flush_i ? bus.new_pc_i : bus.branch_target_i;
    w_redirect_pc = {w_redirect_pc[31:2], 2'b00};
    w_not_empty   = (r_count != '0);
    w_pop         = w_not_empty & bus.id_ready_i;
    // A pop frees the head slot this same edge, so a full FIFO can still accept.
    w_push        = w_ce & ~w_redirect & ((r_count < FULL_COUNT) | w_pop);
  end

  // ---------------------------------------------------------------------------
  // Next-state for PC, pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pc_next    = r_pc;
    w_count_next = r_count;
    w_rptr_next  = r_rptr;
    w_wptr_next  = r_wptr;

    if (w_redirect) begin
      // A pop in this cycle is discarded along with every other queued entry.
      w_pc_next    = w_redirect_pc;
      w_count_next = '0;
      w_rptr_next  = '0;
      w_wptr_next  = '0;
    end else begin
      if (w_push) begin
        w_pc_next   = r_pc + 32'd4;
        w_wptr_next = r_wptr + 1'b1;
      end
      if (w_pop) begin
        w_rptr_next = r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + 1'b1;
        2'b01:   w_count_next = r_count - 1'b1;
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_rptr  <= '0;
      r_wptr  <= '0;
    end else begin
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      r_rptr  <= w_rptr_next;
      r_wptr  <= w_wptr_next;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]   <= r_pc;
      r_mem_inst[r_wptr] <= bus.rom_inst_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.pc_o       = r_pc;
  assign bus.ce_o       = w_ce;
  assign bus.count_o    = r_count;
  assign bus.id_valid_o = w_not_empty;
  assign bus.id_pc_o    = w_not_empty ? r_mem_pc[r_rptr] : 32'h0;
  assign bus.id_inst_o  = w_not_empty ? r_mem_inst[r_rptr] : 32'h0;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the directed scenarios.
module tb_inst_fetch;

  localparam int unsigned   DEPTH    = 4;
  localparam logic [31:0]   RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ROM contents: word index, so ROM[i] = i.
  assign bus.rom_inst_i = bus.pc_o >> 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of {pc, inst} plus the next fetch address.
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc = RESET_PC;
  bit          m_ce = 1'b0;
  logic [63:0] m_q[$];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pc = RESET_PC;
        m_ce = 1'b0;
        m_q.delete();
      end else begin
        bit pop;
        pop = (m_q.size() != 0) && bus.id_ready_i;
        if (bus.flush_i) begin
          m_pc = bus.new_pc_i & 32'hFFFF_FFFC;
          m_q.delete();
        end else if (bus.branch_flag_i) begin
          m_pc = bus.branch_target_i & 32'hFFFF_FFFC;
          m_q.delete();
        end else begin
          if (pop) void'(m_q.pop_front());
          if (m_ce && m_q.size() < DEPTH) begin
            m_q.push_back({m_pc, m_pc >> 2});
            m_pc = m_pc + 32'd4;
          end
        end
        m_ce = 1'b1;
      end
    end
  end

  // Compare process: every falling edge, outputs against the model.
  initial begin
    forever begin
      logic [63:0] head;
      bit          vld;
      @(negedge clk);
      vld  = (m_q.size() != 0);
      head = vld ? m_q[0] : 64'h0;
      check("ce_o", 32'(bus.ce_o), 32'(m_ce));
      check("pc_o", bus.pc_o, m_pc);
      check("count_o", 32'(bus.count_o), m_q.size());
      check("id_valid_o", 32'(bus.id_valid_o), 32'(vld));
      check("id_pc_o", bus.id_pc_o, head[63:32]);
      check("id_inst_o", bus.id_inst_o, head[31:0]);
    end
  end

  // Inputs change 2 time units after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " ce_o"}, 32'(bus.ce_o), 32'h0);
    check({tag, " pc_o"}, bus.pc_o, RESET_PC);
    check({tag, " count_o"}, 32'(bus.count_o), 32'h0);
    check({tag, " id_valid_o"}, 32'(bus.id_valid_o), 32'h0);
    check({tag, " id_pc_o"}, bus.id_pc_o, 32'h0);
    check({tag, " id_inst_o"}, bus.id_inst_o, 32'h0);
  endtask

  initial begin
    logic [15:0] ready_pat;
    bus.flush_i         = 1'b0;
    bus.new_pc_i        = 32'h0;
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = 32'h0;
    bus.id_ready_i      = 1'b1;

    // 1. Reset and startup stream.
    tick(3);
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();
    check("start ce_o", 32'(bus.ce_o), 32'h1);
    check("start pc_o", bus.pc_o, 32'h0);
    check("start count_o", 32'(bus.count_o), 32'h0);
    tick();
    check("first id_valid_o", 32'(bus.id_valid_o), 32'h1);
    check("first id_pc_o", bus.id_pc_o, 32'h0);
    check("first pc_o", bus.pc_o, 32'h4);
    tick();
    check("second id_pc_o", bus.id_pc_o, 32'h4);
    check("second id_inst_o", bus.id_inst_o, 32'h1);
    check("second count_o", 32'(bus.count_o), 32'h1);
    tick(3);

    // 2. Stall: restart at 0 with ready low, FIFO saturates.
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h0;
    bus.id_ready_i      = 1'b0;
    tick();
    bus.branch_flag_i = 1'b0;
    tick(10);
    check("stall count_o", 32'(bus.count_o), 32'h4);
    check("stall pc_o", bus.pc_o, 32'h10);
    check("stall id_pc_o", bus.id_pc_o, 32'h0);

    // 3. Full with ready: push and pop every cycle.
    bus.id_ready_i = 1'b1;
    tick();
    check("full count_o", 32'(bus.count_o), 32'h4);
    check("full id_pc_o", bus.id_pc_o, 32'h4);
    check("full pc_o", bus.pc_o, 32'h14);
    tick(3);
    check("full2 count_o", 32'(bus.count_o), 32'h4);
    check("full2 id_inst_o", bus.id_inst_o, 32'h4);

    // 4. Branch with 3 queued.
    bus.id_ready_i      = 1'b0;
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h0;
    tick();
    bus.branch_flag_i = 1'b0;
    tick(3);
    check("three count_o", 32'(bus.count_o), 32'h3);
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h100;
    tick();
    check("branch count_o", 32'(bus.count_o), 32'h0);
    check("branch pc_o", bus.pc_o, 32'h100);
    bus.branch_flag_i = 1'b0;
    bus.id_ready_i    = 1'b1;
    tick();
    check("branch id_pc_o", bus.id_pc_o, 32'h100);
    check("branch id_inst_o", bus.id_inst_o, 32'h40);

    // 5. Flush beats branch; targets are aligned.
    bus.flush_i         = 1'b1;
    bus.new_pc_i        = 32'h20;
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h40;
    tick();
    check("prio pc_o", bus.pc_o, 32'h20);
    bus.flush_i         = 1'b0;
    bus.branch_target_i = 32'h43;
    tick();
    check("align pc_o", bus.pc_o, 32'h40);
    bus.flush_i       = 1'b1;
    bus.new_pc_i      = 32'h27;
    bus.branch_flag_i = 1'b0;
    tick();
    check("flush align pc_o", bus.pc_o, 32'h24);
    bus.flush_i = 1'b0;

    // Irregular consumer.
    ready_pat = 16'b1011_0010_0111_0100;
    for (int i = 0; i < 16; i++) begin
      bus.id_ready_i = ready_pat[i];
      tick();
    end

    // 6. PC wrap, then reset mid-stream.
    bus.id_ready_i      = 1'b1;
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'hFFFF_FFF8;
    tick();
    bus.branch_flag_i = 1'b0;
    tick(2);
    check("wrap pc_o", bus.pc_o, 32'h0);
    check("wrap id_pc_o", bus.id_pc_o, 32'hFFFF_FFFC);
    check("wrap id_inst_o", bus.id_inst_o, 32'h3FFF_FFFF);
    tick();
    check("wrapped id_pc_o", bus.id_pc_o, 32'h0);
    tick(2);
    rst = 1'b1;
    #1;
    check_zero_outputs("midreset");
    tick(2);
    rst = 1'b0;
    tick();
    check("restart ce_o", 32'(bus.ce_o), 32'h1);
    check("restart pc_o", bus.pc_o, RESET_PC);
    tick();
    check("restart id_pc_o", bus.id_pc_o, RESET_PC);
    check("restart pc_o next", bus.pc_o, RESET_PC + 32'd4);
    tick(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
